// File: rtl/fetch_entry_queue_pkg.sv
// Shared frontend definitions for the fetch -> decode path.
//   MaxVlen       : widest supported virtual address; entries carry this many address bits.
//   fetch_entry_t : one decoded-boundary instruction (address, instruction, fault flag).
//   is_compressed : true when a 16-bit parcel starts a compressed instruction.
package fetch_entry_queue_pkg;

  localparam int unsigned MaxVlen = 64;

  typedef struct packed {
    logic [MaxVlen-1:0] addr;
    logic [31:0]        instr;
    logic               fault;
  } fetch_entry_t;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realign.sv
// Splits a 32-bit fetch word into up to two instruction entries and rejoins instructions that
// straddle two words.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : drops the leftover half
//   accept_i      : the word on addr_i/data_i/fault_i is consumed this cycle
//   push_cnt_o    : number of entries produced (0..2), entry0_o first in address order
//   entry0_o/1_o  : produced entries
module fetch_realign
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            accept_i,
  input  logic [VLEN-1:0] addr_i,
  input  logic [31:0]     data_i,
  input  logic            fault_i,
  output logic [1:0]      push_cnt_o,
  output fetch_entry_t    entry0_o,
  output fetch_entry_t    entry1_o
);

  logic            lo_valid_q, lo_valid_d;
  logic [15:0]     lo_half_q, lo_half_d;
  logic [VLEN-1:0] lo_addr_q, lo_addr_d;

  logic [VLEN-1:0] addr_h, word_addr, upper_addr;
  logic            match;
  logic            take_upper;
  logic            unused_addr0;

  assign addr_h       = {addr_i[VLEN-1:1], 1'b0};
  assign word_addr    = {addr_i[VLEN-1:2], 2'b00};
  assign upper_addr   = word_addr + VLEN'(2);
  assign unused_addr0 = addr_i[0];
  // A leftover is only joined when the next word continues right behind it.
  assign match        = lo_valid_q && (addr_h == lo_addr_q + VLEN'(2));

  always_comb begin
    push_cnt_o = 2'd0;
    entry0_o   = '0;
    entry1_o   = '0;
    lo_valid_d = lo_valid_q;
    lo_half_d  = lo_half_q;
    lo_addr_d  = lo_addr_q;
    take_upper = 1'b0;
    if (accept_i) begin
      // Consumed or stale either way; only an uncompressed upper half re-arms it.
      lo_valid_d = 1'b0;
      if (fault_i) begin
        push_cnt_o     = 2'd1;
        entry0_o.addr  = MaxVlen'(match ? lo_addr_q : addr_h);
        entry0_o.fault = 1'b1;
      end else begin
        if (match) begin
          push_cnt_o     = 2'd1;
          entry0_o.addr  = MaxVlen'(lo_addr_q);
          entry0_o.instr = {data_i[15:0], lo_half_q};
          take_upper     = 1'b1;
        end else if (!addr_i[1]) begin
          push_cnt_o    = 2'd1;
          entry0_o.addr = MaxVlen'(word_addr);
          if (is_compressed(data_i[15:0])) begin
            entry0_o.instr = {16'h0, data_i[15:0]};
            take_upper     = 1'b1;
          end else begin
            entry0_o.instr = data_i;
          end
        end else begin
          take_upper = 1'b1;
        end

        if (take_upper) begin
          if (is_compressed(data_i[31:16])) begin
            if (push_cnt_o == 2'd0) begin
              entry0_o.addr  = MaxVlen'(upper_addr);
              entry0_o.instr = {16'h0, data_i[31:16]};
            end else begin
              entry1_o.addr  = MaxVlen'(upper_addr);
              entry1_o.instr = {16'h0, data_i[31:16]};
            end
            push_cnt_o = push_cnt_o + 2'd1;
          end else begin
            lo_valid_d = 1'b1;
            lo_half_d  = data_i[31:16];
            lo_addr_d  = upper_addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      lo_valid_q <= 1'b0;
      lo_half_q  <= '0;
      lo_addr_q  <= '0;
    end else begin
      lo_valid_q <= lo_valid_d;
      lo_half_q  <= lo_half_d;
      lo_addr_q  <= lo_addr_d;
    end
  end

endmodule

// File: rtl/fetch_entry_queue.sv
// Fetch-side producer of the fetch -> decode handshake: realigns fetch words into instruction
// entries, buffers them in a Depth-entry FIFO and presents the head entries on NrIssuePorts lanes.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i               : drops buffered entries and any partial instruction
//   fetch_valid_i/ready_o : fetch word handshake (addr, data, fault)
//   entry_valid_o/ready_i : per-lane decode handshake; lane 1 pops only together with lane 0
//   entry_addr/instr/fault_o : per-lane entry contents
module fetch_entry_queue
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned NrIssuePorts = 1,
  parameter int unsigned VLEN         = 64,
  parameter int unsigned Depth        = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                fetch_valid_i,
  output logic                                fetch_ready_o,
  input  logic [VLEN-1:0]                     fetch_addr_i,
  input  logic [31:0]                         fetch_data_i,
  input  logic                                fetch_fault_i,
  output logic [NrIssuePorts-1:0]             entry_valid_o,
  input  logic [NrIssuePorts-1:0]             entry_ready_i,
  output logic [NrIssuePorts-1:0][VLEN-1:0]   entry_addr_o,
  output logic [NrIssuePorts-1:0][31:0]       entry_instr_o,
  output logic [NrIssuePorts-1:0]             entry_fault_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
  logic [CntW-1:0] count_q, count_d;

  logic            accept;
  logic [1:0]      push_cnt, pop_cnt;
  fetch_entry_t    entry0, entry1;
  logic [1:0]      valid_pad, ready_pad;

  // Space comes from the registered count only, so decode never sees a fetch -> entry path.
  assign fetch_ready_o = !rst_i && !flush_i && ((CntW'(Depth) - count_q) >= CntW'(2));
  assign accept        = fetch_valid_i && fetch_ready_o;

  fetch_realign #(
    .VLEN (VLEN)
  ) u_realign (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .accept_i   (accept),
    .addr_i     (fetch_addr_i),
    .data_i     (fetch_data_i),
    .fault_i    (fetch_fault_i),
    .push_cnt_o (push_cnt),
    .entry0_o   (entry0),
    .entry1_o   (entry1)
  );

  for (genvar g = 0; g < NrIssuePorts; g++) begin : g_lane
    logic [PtrW-1:0] idx;
    assign idx              = head_q + PtrW'(g);
    assign entry_valid_o[g] = count_q > CntW'(g);
    assign entry_addr_o[g]  = mem_q[idx].addr[VLEN-1:0];
    assign entry_instr_o[g] = mem_q[idx].instr;
    assign entry_fault_o[g] = mem_q[idx].fault;
  end

  // Zero-padded to two lanes so a single-lane build never pops lane 1.
  assign valid_pad = 2'(entry_valid_o);
  assign ready_pad = 2'(entry_ready_i);
  assign pop_cnt   = {1'b0, ready_pad[0] & valid_pad[0]}
                   + {1'b0, ready_pad[1] & valid_pad[1] & ready_pad[0]};

  assign tail_p1 = tail_q + PtrW'(1);

  always_comb begin
    head_d  = head_q + PtrW'(pop_cnt);
    tail_d  = tail_q + PtrW'(push_cnt);
    count_d = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (!flush_i && push_cnt != 2'd0) begin
        mem_q[tail_q] <= entry0;
        if (push_cnt == 2'd2) begin
          mem_q[tail_p1] <= entry1;
        end
      end
    end
  end

endmodule
